pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer for the fetch stage, successor to the fixed 32-bit PC unit.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage control/return-bus bundle for pc_sequencer.
// The master drives the controls and memory beats, and the slave (the sequencer) drives the PC outputs.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              stall;
    logic              branch_en;
    logic [DATA_W-1:0] branch_target;
    logic              call_en;
    logic [DATA_W-1:0] call_target;
    logic              ret_start;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              irq_req;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] epc;
    logic              irq_ack;
    logic              ret_busy;

    modport master (
        output stall, branch_en, branch_target, call_en, call_target,
        output ret_start, mem_valid, mem_data, irq_req,
        input  pc, epc, irq_ack, ret_busy
    );

    modport slave (
        input  stall, branch_en, branch_target, call_en, call_target,
        input  ret_start, mem_valid, mem_data, irq_req,
        output pc, epc, irq_ack, ret_busy
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. It picks the next PC from increment, branch, call, stall or the interrupt vector,
// and it assembles multi-beat return addresses. All state changes on the falling clock edge.
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'd32),
    parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(32'd0)
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int BEATS = ADDR_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        RET_LOAD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              irq_ack_q, irq_ack_d;
    logic              ret_busy_q, ret_busy_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] asm_q, asm_d;

    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] asm_beat_s;
    logic              irq_take_s;

    // PC that the non-interrupt IDLE rows would select; it also serves as the resume address.
    always_comb begin
        seq_pc_s = pc_q + ADDR_W'(1'b1);
        if (bus.call_en) begin
            seq_pc_s = ADDR_W'(bus.call_target);
        end else if (bus.branch_en) begin
            seq_pc_s = ADDR_W'(bus.branch_target);
        end else if (bus.stall) begin
            seq_pc_s = pc_q;
        end else begin
            seq_pc_s = pc_q + ADDR_W'(1'b1);
        end
    end

    // Assembly register with the current beat merged in; beat 0 lands in the most-significant word.
    always_comb begin
        asm_beat_s = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            asm_beat_s[ADDR_W-1-b*DATA_W -: DATA_W] =
                (cnt_q == CNT_W'(b)) ? bus.mem_data : asm_q[ADDR_W-1-b*DATA_W -: DATA_W];
        end
    end

    // Interrupts are only taken from IDLE, so a load that completes this edge defers the irq by one edge.
    always_comb begin
        irq_take_s = (state_q == IDLE) && (pending_q || bus.irq_req);
    end

    // Next-state and datapath selection for the two-state return-load FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        irq_ack_d = 1'b0;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        pending_d = irq_take_s ? 1'b0 : (pending_q | bus.irq_req);

        case (state_q)
            IDLE: begin
                if (irq_take_s) begin
                    pc_d      = INT_VEC;
                    irq_ack_d = 1'b1;
                    // A return that collides with the irq is re-issued later, so resume at the current pc.
                    epc_d     = bus.ret_start ? pc_q : seq_pc_s;
                end else if (bus.ret_start) begin
                    state_d = RET_LOAD;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    pc_d = seq_pc_s;
                end
            end
            RET_LOAD: begin
                if (bus.mem_valid) begin
                    asm_d = asm_beat_s;
                    if (cnt_q == LAST_CNT) begin
                        pc_d    = asm_beat_s;
                        state_d = IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end else begin
                    asm_d = asm_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        ret_busy_d = (state_d == RET_LOAD);
    end

    // State registers; the async reset also discards any return load in progress.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            epc_q      <= {ADDR_W{1'b0}};
            irq_ack_q  <= 1'b0;
            ret_busy_q <= 1'b0;
            pending_q  <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            asm_q      <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            irq_ack_q  <= irq_ack_d;
            ret_busy_q <= ret_busy_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.epc      = epc_q;
    assign bus.irq_ack  = irq_ack_q;
    assign bus.ret_busy = ret_busy_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a 32-bit (2-beat) instance and a 48-bit (3-beat) instance.
// Expected outputs are queued as each step is driven, then popped after the falling edge.
module tb_pc_sequencer;
    logic clk = 1'b1;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(32), .DATA_W(16)) if32 ();
    pc_sequencer_if #(.ADDR_W(48), .DATA_W(16)) if48 ();

    pc_sequencer #(.ADDR_W(32), .DATA_W(16), .RESET_VEC(32'd32), .INT_VEC(32'd0)) dut32 (
        .clk(clk), .reset(reset), .bus(if32.slave));
    pc_sequencer #(.ADDR_W(48), .DATA_W(16), .RESET_VEC(48'd32), .INT_VEC(48'd0)) dut48 (
        .clk(clk), .reset(reset), .bus(if48.slave));

    localparam logic [5:0] N = 6'b000000, S = 6'b100000, B = 6'b010000, C = 6'b001000;
    localparam logic [5:0] R = 6'b000100, V = 6'b000010, I = 6'b000001;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] bt, ct, md;
        logic [63:0] pc;
        bit          busy, ack, ce;
        logic [63:0] epc;
    } step_t;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic step_t mk(logic [5:0] ctl, logic [15:0] bt, logic [15:0] ct, logic [15:0] md,
                                 logic [63:0] pc, bit busy, bit ack, bit ce, logic [63:0] epc);
        step_t s;
        s.ctl = ctl; s.bt = bt; s.ct = ct; s.md = md;
        s.pc = pc; s.busy = busy; s.ack = ack; s.ce = ce; s.epc = epc;
        return s;
    endfunction

    function automatic logic [63:0] obs(int sel);
        case (sel)
            0: return 64'(if32.pc);
            1: return 64'(if32.epc);
            2: return 64'(if32.irq_ack);
            3: return 64'(if32.ret_busy);
            4: return 64'(if48.pc);
            5: return 64'(if48.epc);
            6: return 64'(if48.irq_ack);
            7: return 64'(if48.ret_busy);
            default: return 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    task automatic idle_all();
        {if32.stall, if32.branch_en, if32.call_en, if32.ret_start, if32.mem_valid, if32.irq_req} = 6'b0;
        {if48.stall, if48.branch_en, if48.call_en, if48.ret_start, if48.mem_valid, if48.irq_req} = 6'b0;
        if32.branch_target = 16'h0; if32.call_target = 16'h0; if32.mem_data = 16'h0;
        if48.branch_target = 16'h0; if48.call_target = 16'h0; if48.mem_data = 16'h0;
    endtask

    task automatic drive(step_t s, bit wide);
        idle_all();
        if (wide) begin
            {if48.stall, if48.branch_en, if48.call_en, if48.ret_start, if48.mem_valid, if48.irq_req} = s.ctl;
            if48.branch_target = s.bt; if48.call_target = s.ct; if48.mem_data = s.md;
        end else begin
            {if32.stall, if32.branch_en, if32.call_en, if32.ret_start, if32.mem_valid, if32.irq_req} = s.ctl;
            if32.branch_target = s.bt; if32.call_target = s.ct; if32.mem_data = s.md;
        end
    endtask

    task automatic push_step(string tag, step_t s, int base);
        sb.push_back('{name: {tag, ".pc"},   sel: base,     val: s.pc});
        sb.push_back('{name: {tag, ".ack"},  sel: base + 2, val: 64'(s.ack)});
        sb.push_back('{name: {tag, ".busy"}, sel: base + 3, val: 64'(s.busy)});
        if (s.ce) sb.push_back('{name: {tag, ".epc"}, sel: base + 1, val: s.epc});
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        step_t st[$];
        idle_all();
        reset = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        sb.push_back('{name: "rst.pc32",   sel: 0, val: 64'd32});
        sb.push_back('{name: "rst.epc32",  sel: 1, val: 64'd0});
        sb.push_back('{name: "rst.ack32",  sel: 2, val: 64'd0});
        sb.push_back('{name: "rst.busy32", sel: 3, val: 64'd0});
        sb.push_back('{name: "rst.pc48",   sel: 4, val: 64'd32});
        sb.push_back('{name: "rst.epc48",  sel: 5, val: 64'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
            end
        end
        reset = 1'b1;
        st.push_back(mk(R, 0, 0, 0,       64'h20, 1, 0, 0, 0));
        st.push_back(mk(V, 0, 0, 16'hDEAD, 64'h20, 1, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i], 1'b0);
            push_step($sformatf("t1a.%0d", i), st[i], 0);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
        // Asynchronous reset mid-load, checked between edges.
        idle_all();
        reset = 1'b0;
        #1;
        sb.push_back('{name: "t1.midrst.pc",   sel: 0, val: 64'h20});
        sb.push_back('{name: "t1.midrst.busy", sel: 3, val: 64'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
            end
        end
        reset = 1'b1;
        st.delete();
        st.push_back(mk(R, 0, 0, 0,        64'h20,       1, 0, 0, 0));
        st.push_back(mk(V, 0, 0, 16'hABCD, 64'h20,       1, 0, 0, 0));
        st.push_back(mk(V, 0, 0, 16'h0001, 64'hABCD0001, 0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i], 1'b0);
            push_step($sformatf("t1b.%0d", i), st[i], 0);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_increment();
        exp_t e;
        step_t st[$];
        do_reset();
        st.push_back(mk(N, 0, 0, 0,        64'd33,        0, 0, 0, 0));
        st.push_back(mk(N, 0, 0, 0,        64'd34,        0, 0, 0, 0));
        st.push_back(mk(N, 0, 0, 0,        64'd35,        0, 0, 0, 0));
        st.push_back(mk(R, 0, 0, 0,        64'd35,        1, 0, 0, 0));
        st.push_back(mk(V, 0, 0, 16'hFFFF, 64'd35,        1, 0, 0, 0));
        st.push_back(mk(V, 0, 0, 16'hFFFF, 64'hFFFFFFFF,  0, 0, 0, 0));
        st.push_back(mk(N, 0, 0, 0,        64'd0,         0, 0, 0, 0));
        st.push_back(mk(N, 0, 0, 0,        64'd1,         0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i], 1'b0);
            push_step($sformatf("t2.%0d", i), st[i], 0);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        step_t st[$];
        do_reset();
        st.push_back(mk(S | B | C,         16'h0200, 16'h0100, 0, 64'h100, 0, 0, 0, 0));
        st.push_back(mk(B,                 16'h0200, 0,        0, 64'h200, 0, 0, 0, 0));
        st.push_back(mk(S | B,             16'h0300, 0,        0, 64'h300, 0, 0, 0, 0));
        st.push_back(mk(S,                 0,        0,        0, 64'h300, 0, 0, 0, 0));
        st.push_back(mk(R | C | S,         0,        16'h0500, 0, 64'h300, 1, 0, 0, 0));
        st.push_back(mk(R | B | C | S,     16'h0600, 16'h0700, 0, 64'h300, 1, 0, 0, 0));
        st.push_back(mk(V | B,             16'h0800, 0, 16'h0000, 64'h300, 1, 0, 0, 0));
        st.push_back(mk(V,                 0,        0, 16'h0042, 64'h42,  0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i], 1'b0);
            push_step($sformatf("t3.%0d", i), st[i], 0);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_return();
        exp_t e;
        step_t st[$];
        do_reset();
        st.push_back(mk(R, 0, 0, 0,        64'd32,        1, 0, 0, 0));
        st.push_back(mk(V, 0, 0, 16'h1234, 64'd32,        1, 0, 0, 0));
        st.push_back(mk(N, 0, 0, 16'h9999, 64'd32,        1, 0, 0, 0));
        st.push_back(mk(V, 0, 0, 16'h5678, 64'h12345678,  0, 0, 0, 0));
        st.push_back(mk(N, 0, 0, 0,        64'h12345679,  0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i], 1'b0);
            push_step($sformatf("t4.%0d", i), st[i], 0);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_irq();
        exp_t e;
        step_t st[$];
        do_reset();
        st.push_back(mk(B,     16'h0028, 0,        0, 64'h28, 0, 0, 0, 0));
        st.push_back(mk(I,     0,        0,        0, 64'h0,  0, 1, 1, 64'h29));
        st.push_back(mk(N,     0,        0,        0, 64'h1,  0, 0, 1, 64'h29));
        st.push_back(mk(B,     16'h0028, 0,        0, 64'h28, 0, 0, 0, 0));
        st.push_back(mk(I | S, 0,        0,        0, 64'h0,  0, 1, 1, 64'h28));
        st.push_back(mk(I | C, 0,        16'h0077, 0, 64'h0,  0, 1, 1, 64'h77));
        st.push_back(mk(B,     16'h0050, 0,        0, 64'h50, 0, 0, 0, 0));
        st.push_back(mk(I | R, 0,        0,        0, 64'h0,  0, 1, 1, 64'h50));
        st.push_back(mk(N,     0,        0,        0, 64'h1,  0, 0, 1, 64'h50));
        foreach (st[i]) begin
            drive(st[i], 1'b0);
            push_step($sformatf("t5.%0d", i), st[i], 0);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        step_t st[$];
        do_reset();
        st.push_back(mk(I, 0, 0, 0, 64'h0, 0, 1, 1, 64'd33));
        st.push_back(mk(I, 0, 0, 0, 64'h0, 0, 1, 1, 64'd1));
        st.push_back(mk(N, 0, 0, 0, 64'h1, 0, 0, 1, 64'd1));
        foreach (st[i]) begin
            drive(st[i], 1'b0);
            push_step($sformatf("b2b.%0d", i), st[i], 0);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_irq_during_ret();
        exp_t e;
        step_t st[$];
        do_reset();
        st.push_back(mk(R,     0, 0, 0,        64'd32,        1, 0, 0, 0));
        st.push_back(mk(V | I, 0, 0, 16'hCAFE, 64'd32,        1, 0, 0, 0));
        st.push_back(mk(N,     0, 0, 0,        64'd32,        1, 0, 0, 0));
        st.push_back(mk(V,     0, 0, 16'hF00D, 64'hCAFEF00D,  0, 0, 0, 0));
        st.push_back(mk(N,     0, 0, 0,        64'h0,         0, 1, 1, 64'hCAFEF00E));
        st.push_back(mk(N,     0, 0, 0,        64'h1,         0, 0, 1, 64'hCAFEF00E));
        foreach (st[i]) begin
            drive(st[i], 1'b0);
            push_step($sformatf("t6.%0d", i), st[i], 0);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_wide();
        exp_t e;
        step_t st[$];
        do_reset();
        st.push_back(mk(R,     0, 0, 0,        64'd32,            1, 0, 0, 0));
        st.push_back(mk(V | I, 0, 0, 16'h1111, 64'd32,            1, 0, 0, 0));
        st.push_back(mk(V,     0, 0, 16'h2222, 64'd32,            1, 0, 0, 0));
        st.push_back(mk(N,     0, 0, 16'h7777, 64'd32,            1, 0, 0, 0));
        st.push_back(mk(V,     0, 0, 16'h3333, 64'h111122223333,  0, 0, 0, 0));
        st.push_back(mk(N,     0, 0, 0,        64'h0,             0, 1, 1, 64'h111122223334));
        st.push_back(mk(N,     0, 0, 0,        64'h1,             0, 0, 1, 64'h111122223334));
        foreach (st[i]) begin
            drive(st[i], 1'b1);
            push_step($sformatf("t6w.%0d", i), st[i], 4);
            @(negedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", e.name, obs(e.sel), e.val);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_increment();
        test_priority();
        test_return();
        test_irq();
        test_back_to_back();
        test_irq_during_ret();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
